fp_regfile_mp: RTL and testbench
================================

# fp_regfile_mp

Parametrised multi-port floating-point register file with an integrated pending-write scoreboard, for the FP execute cluster of the pipelined core. It has configurable element width, depth, read-port count and write-port count, and optional NaN-boxing of single-precision writes when FLEN=64. A per-register pending bit tracks long-latency FP results in flight (FDIV/FSQRT/FMA), so issue logic can stall on RAW/WAW hazards. Read ports are combinational. Writes and scoreboard updates are registered.

## Interface
Parameters:
- FLEN, 32, register width in bits; legal values are 32 and 64.
- DEPTH, 32, number of registers; must be a power of two and at least 2. AW = $clog2(DEPTH).
- NUM_RD, 3, number of read ports.
- NUM_WR, 2, number of write ports.
- ZERO_R0, 0, when 1, register 0 reads as zero and ignores writes and issues. Keep at 0 for the RISC-V F/D file, where f0 is a normal register.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rd_addr_i  in  [NUM_RD][AW]  read addresses.
- rd_data_o  out  [NUM_RD][FLEN]  read data.
- rd_busy_o  out  [NUM_RD]  the addressed register has a pending write.
- wr_en_i  in  [NUM_WR]  write enables.
- wr_addr_i  in  [NUM_WR][AW]  write addresses.
- wr_data_i  in  [NUM_WR][FLEN]  write data.
- wr_single_i  in  [NUM_WR]  the write is a single-precision result and must be NaN-boxed.
- issue_en_i  in  1  a long-latency op has issued; sets the pending bit of its destination.
- issue_addr_i  in  AW  destination register of the issued op.
- flush_i  in  1  clears all pending bits; used on pipeline flush or trap.
- any_busy_o  out  1  OR of all pending bits; used by fence and CSR-drain logic.

## Operation
- Storage: DEPTH x FLEN flops. Reset sets every register and every pending bit to 0.
- Write: on the posedge, for each port w with wr_en_i[w]=1, mem[wr_addr_i[w]] <= boxed data.
- NaN-boxing: when FLEN=64 and wr_single_i[w]=1, boxed data = {32'hFFFF_FFFF, wr_data_i[w][31:0]}. Otherwise boxed data = wr_data_i[w]. When FLEN=32, wr_single_i is ignored.
- Same-address collision between write ports: the highest-indexed port wins. The losing data is dropped silently.
- Read: rd_data_o[r] = mem[rd_addr_i[r]], purely combinational. With ZERO_R0=1, address 0 returns 0.
- Scoreboard: pending[a] is set on a cycle with issue_en_i and issue_addr_i=a. It is cleared by any enabled write to a.
- Issue and write to the same address in the same cycle: pending ends set, because the new producer dominates.
- flush_i: clears every pending bit. flush_i has priority over a same-cycle issue. Same-cycle writes still update storage.
- ZERO_R0=1: writes and issues to address 0 are ignored, and rd_busy_o for address 0 is always 0.
- rd_busy_o[r] = pending[rd_addr_i[r]], subject to the bypass rule in Configuration. any_busy_o = |pending.

## Timing
- Read latency is 0 cycles, combinational from rd_addr_i.
- Write latency is 1 cycle. Data is visible on the read ports the cycle after wr_en_i, unless bypass is enabled.
- Scoreboard latency is 1 cycle. A register issued in cycle N reads busy from cycle N+1 onward.
- Reset may assert mid-operation. It immediately clears storage and pending bits asynchronously; no handshake is in progress.
- All outputs during reset: rd_data_o = 0, rd_busy_o = 0, any_busy_o = 0.

## Configuration
- Macro FP_RF_BYPASS_EN.
- Defined: write-to-read forwarding. If any enabled write port targets rd_addr_i[r] in the current cycle, rd_data_o[r] is the boxed data of the highest-indexed such port. In that case rd_busy_o[r] = 0, unless issue_en_i targets the same address in the same cycle.
- Undefined: reads always return stored contents. rd_busy_o reflects the registered pending bits only, and the consumer waits one extra cycle.

## Structure
- Shared package fp_rf_pkg holds:
  - the FLEN_SP=32 constant;
  - the NANBOX_HI=32'hFFFF_FFFF constant;
  - the nanbox() function;
  - a wr_req_t struct {en, addr, data, single} used by writeback.
- Sub-module fp_rf_scoreboard (DEPTH pending flops, set/clear/flush priority, any_busy) is instantiated once. Storage, read muxing and bypass stay in the top module.

## Test plan
- Reset, then read all registers on 3 ports: every read returns 0, busy=0, any_busy=0.
- FLEN=64: write f5 with 32'h3F80_0000 and wr_single=1, read f5 next cycle: returns 64'hFFFF_FFFF_3F80_0000. A double-precision write of 64'h4000_0000_0000_0000 reads back unchanged.
- Both write ports write f7 in the same cycle (port0=0x11, port1=0x22): f7 reads 0x22.
- Issue f3 in cycle N: busy=1 from N+1. Write f3 in cycle M: busy=0 from M+1. Issue and write f3 in the same cycle: busy stays 1.
- Issue f1, f2 and f9, then assert flush_i with a concurrent issue of f4: all pending bits clear and any_busy=0 next cycle.
- With FP_RF_BYPASS_EN, write f8=0xABCD while reading f8 in the same cycle: rd_data=0xABCD and busy=0. Without the macro, the same-cycle read returns the old value and the next-cycle read returns 0xABCD.

Source files
------------

// File: rtl/fp_rf_pkg.sv
// Shared types and helpers for the FP register file: NaN-boxing constants,
// the nanbox() helper and the writeback request struct.
package fp_rf_pkg;

  localparam int          FLEN_SP   = 32;
  localparam logic [31:0] NANBOX_HI = 32'hFFFF_FFFF;

  // The writeback struct is sized for the widest legal configuration.
  // Narrower builds zero-extend into it and truncate on the way out.
  localparam int MAX_FLEN = 64;
  localparam int MAX_AW   = 16;

  typedef struct packed {
    logic                en;
    logic [MAX_AW-1:0]   addr;
    logic [MAX_FLEN-1:0] data;
    logic                single;
  } wr_req_t;

  // A single-precision result held in a 64-bit register gets its upper
  // half forced to all ones, so it reads as a quiet NaN if used as a double.
  function automatic logic [MAX_FLEN-1:0] nanbox(input logic [MAX_FLEN-1:0] data,
                                                 input logic                single,
                                                 input logic                flen64);
    if (flen64 && single) return {NANBOX_HI, data[FLEN_SP-1:0]};
    return data;
  endfunction

endpackage

// File: rtl/fp_regfile_mp_if.sv
// Read, writeback and issue/flush bundle of the multi-port FP register file.
// master = pipeline side, slave = register file.
interface fp_regfile_mp_if #(
  parameter int FLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 3,
  parameter int NUM_WR = 2
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]     rd_addr_i    [NUM_RD];
  logic [FLEN-1:0]   rd_data_o    [NUM_RD];
  logic [NUM_RD-1:0] rd_busy_o;

  logic [NUM_WR-1:0] wr_en_i;
  logic [AW-1:0]     wr_addr_i    [NUM_WR];
  logic [FLEN-1:0]   wr_data_i    [NUM_WR];
  logic [NUM_WR-1:0] wr_single_i;

  logic              issue_en_i;
  logic [AW-1:0]     issue_addr_i;
  logic              flush_i;
  logic              any_busy_o;

  modport master (
    output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_single_i,
           issue_en_i, issue_addr_i, flush_i,
    input  rd_data_o, rd_busy_o, any_busy_o
  );

  modport slave (
    input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, wr_single_i,
           issue_en_i, issue_addr_i, flush_i,
    output rd_data_o, rd_busy_o, any_busy_o
  );

endinterface

// File: rtl/fp_rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared by
// writeback, all cleared by flush. Priority: flush > issue > writeback clear.
module fp_rf_scoreboard #(
  parameter int DEPTH   = 32,
  parameter int ZERO_R0 = 0,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  input  logic [DEPTH-1:0] wr_clr,
  input  logic             flush,
  output logic [DEPTH-1:0] pending,
  output logic             any_busy
);

  logic [DEPTH-1:0] pending_nxt;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the ifs leaves it unassigned and infers a latch.
  always_comb begin
    pending_nxt = pending;
    for (int a = 0; a < DEPTH; a++) begin
      if (flush) begin
        pending_nxt[a] = 1'b0;
      end else if (issue_en && issue_addr == AW'(a)) begin
        pending_nxt[a] = 1'b1;
      end else if (wr_clr[a]) begin
        pending_nxt[a] = 1'b0;
      end
    end
    if (ZERO_R0 != 0) pending_nxt[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign any_busy = |pending;

endmodule

// File: rtl/fp_regfile_mp.sv
// Multi-port FP register file with pending-write scoreboard.
// Optional write-to-read forwarding is enabled by defining FP_RF_BYPASS_EN.
module fp_regfile_mp
  import fp_rf_pkg::*;
#(
  parameter int FLEN    = 32,
  parameter int DEPTH   = 32,
  parameter int NUM_RD  = 3,
  parameter int NUM_WR  = 2,
  parameter int ZERO_R0 = 0
) (
  input logic            clk,
  input logic            rst_n,
  fp_regfile_mp_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  wr_req_t          req   [NUM_WR];
  logic [FLEN-1:0]  boxed [NUM_WR];
  logic [DEPTH-1:0] wr_hit;
  logic [FLEN-1:0]  wr_val [DEPTH];
  logic [FLEN-1:0]  mem    [DEPTH];
  logic [DEPTH-1:0] pending;
  logic             any_busy;

  always_comb begin
    for (int w = 0; w < NUM_WR; w++) begin
      req[w].en     = bus.wr_en_i[w];
      req[w].addr   = MAX_AW'(bus.wr_addr_i[w]);
      req[w].data   = MAX_FLEN'(bus.wr_data_i[w]);
      req[w].single = bus.wr_single_i[w];
      boxed[w]      = FLEN'(nanbox(req[w].data, req[w].single, FLEN == 64));
    end
  end

  // Per-register write select; scanning ports upward lets the highest port win.
  always_comb begin
    wr_hit = '0;
    for (int a = 0; a < DEPTH; a++) begin
      wr_val[a] = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if (req[w].en && req[w].addr == MAX_AW'(a) && !(ZERO_R0 != 0 && a == 0)) begin
          wr_hit[a] = 1'b1;
          wr_val[a] = boxed[w];
        end
      end
    end
  end

  // NOTE: the storage array is reset explicitly because reads must return zero
  // after reset; a plain RAM macro would not, so this stays as flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
    end else begin
      for (int a = 0; a < DEPTH; a++) begin
        if (wr_hit[a]) mem[a] <= wr_val[a];
      end
    end
  end

  fp_rf_scoreboard #(
    .DEPTH   (DEPTH),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_en   (bus.issue_en_i),
    .issue_addr (bus.issue_addr_i),
    .wr_clr     (wr_hit),
    .flush      (bus.flush_i),
    .pending    (pending),
    .any_busy   (any_busy)
  );

  assign bus.any_busy_o = any_busy;

  always_comb begin
    for (int r = 0; r < NUM_RD; r++) begin
      bus.rd_data_o[r] = mem[bus.rd_addr_i[r]];
      bus.rd_busy_o[r] = pending[bus.rd_addr_i[r]];
`ifdef FP_RF_BYPASS_EN
      // A same-cycle writer satisfies the read; only a same-cycle issue
      // to that register makes it pending again.
      for (int w = 0; w < NUM_WR; w++) begin
        if (rst_n && req[w].en && req[w].addr == MAX_AW'(bus.rd_addr_i[r])) begin
          bus.rd_data_o[r] = boxed[w];
          bus.rd_busy_o[r] = bus.issue_en_i && (bus.issue_addr_i == bus.rd_addr_i[r]);
        end
      end
`endif
      if (ZERO_R0 != 0 && bus.rd_addr_i[r] == '0) begin
        bus.rd_data_o[r] = '0;
        bus.rd_busy_o[r] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_regfile_mp.sv
// Self-checking bench for fp_regfile_mp (FLEN=64, 3 read / 2 write ports)
// against an array-based reference model of the register file and scoreboard.
module tb_fp_regfile_mp;

  localparam int FLEN   = 64;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 3;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_regfile_mp_if #(.FLEN(FLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) bus ();

  fp_regfile_mp #(
    .FLEN(FLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ZERO_R0(0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [63:0] ref_mem  [DEPTH];
  bit          ref_pend [DEPTH];

  function automatic logic [63:0] box(input logic [63:0] d, input bit single);
    logic [31:0] lo;
    lo = d[31:0];
    return single ? {32'hFFFF_FFFF, lo} : d;
  endfunction

  // Value a read of register a should show right now, before the next edge.
  function automatic logic [63:0] exp_data(input int a);
    logic [63:0] v;
    v = ref_mem[a];
`ifdef FP_RF_BYPASS_EN
    for (int w = 0; w < NUM_WR; w++)
      if (bus.wr_en_i[w] && int'(bus.wr_addr_i[w]) == a)
        v = box(bus.wr_data_i[w], bus.wr_single_i[w]);
`endif
    return v;
  endfunction

  function automatic bit exp_busy(input int a);
    bit b;
    b = ref_pend[a];
`ifdef FP_RF_BYPASS_EN
    for (int w = 0; w < NUM_WR; w++)
      if (bus.wr_en_i[w] && int'(bus.wr_addr_i[w]) == a)
        b = bus.issue_en_i && int'(bus.issue_addr_i) == a;
`endif
    return b;
  endfunction

  function automatic bit exp_any();
    bit b = 0;
    for (int a = 0; a < DEPTH; a++) b |= ref_pend[a];
    return b;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      ref_mem[a]  = '0;
      ref_pend[a] = 1'b0;
    end
  endtask

  task automatic idle();
    bus.wr_en_i      = '0;
    bus.wr_single_i  = '0;
    bus.issue_en_i   = 1'b0;
    bus.issue_addr_i = '0;
    bus.flush_i      = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      bus.wr_addr_i[w] = '0;
      bus.wr_data_i[w] = '0;
    end
  endtask

  task automatic drive_wr(input int w, input int a, input logic [63:0] d, input bit single);
    bus.wr_en_i[w]     = 1'b1;
    bus.wr_addr_i[w]   = AW'(a);
    bus.wr_data_i[w]   = d;
    bus.wr_single_i[w] = single;
  endtask

  // One clock edge: the model applies whatever is being driven, then 1 ns settles.
  task automatic tick();
    @(posedge clk);
    for (int w = 0; w < NUM_WR; w++)
      if (bus.wr_en_i[w])
        ref_mem[bus.wr_addr_i[w]] = box(bus.wr_data_i[w], bus.wr_single_i[w]);
    if (bus.flush_i) begin
      for (int a = 0; a < DEPTH; a++) ref_pend[a] = 1'b0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (bus.wr_en_i[w]) ref_pend[bus.wr_addr_i[w]] = 1'b0;
      if (bus.issue_en_i) ref_pend[bus.issue_addr_i] = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    idle();
    for (int r = 0; r < NUM_RD; r++) bus.rd_addr_i[r] = AW'(r);
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if (bus.any_busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_any_busy_in_reset got=%b want=0", bus.any_busy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      for (int r = 0; r < NUM_RD; r++) bus.rd_addr_i[r] = AW'((a + r) % DEPTH);
      tick();
      #2;
      for (int r = 0; r < NUM_RD; r++) begin
        checks++;
        if (bus.rd_data_o[r] !== 64'h0 || bus.rd_busy_o[r] !== 1'b0) begin
          failures++;
          $display("FAIL reset_read port=%0d addr=%0d got=%h/%b want=0/0",
                   r, (a + r) % DEPTH, bus.rd_data_o[r], bus.rd_busy_o[r]);
        end
      end
      checks++;
      if (bus.any_busy_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_any_busy got=%b want=0", bus.any_busy_o);
      end
    end
  endtask

  task automatic test_nanbox();
    idle();
    drive_wr(0, 5, 64'h0000_0000_3F80_0000, 1'b1);
    drive_wr(1, 6, 64'h4000_0000_0000_0000, 1'b0);
    bus.rd_addr_i[0] = 5'd5;
    #2;
    checks++;
    if (bus.rd_data_o[0] !== exp_data(5)) begin
      failures++;
      $display("FAIL nanbox_same_cycle got=%h want=%h", bus.rd_data_o[0], exp_data(5));
    end
    tick();
    idle();
    bus.rd_addr_i[0] = 5'd5;
    bus.rd_addr_i[1] = 5'd6;
    #2;
    checks++;
    if (bus.rd_data_o[0] !== 64'hFFFF_FFFF_3F80_0000) begin
      failures++;
      $display("FAIL nanbox_single got=%h want=ffffffff3f800000", bus.rd_data_o[0]);
    end
    checks++;
    if (bus.rd_data_o[1] !== 64'h4000_0000_0000_0000) begin
      failures++;
      $display("FAIL nanbox_double got=%h want=4000000000000000", bus.rd_data_o[1]);
    end
    drive_wr(1, 11, 64'hDEAD_BEEF_1234_5678, 1'b1);
    tick();
    idle();
    bus.rd_addr_i[2] = 5'd11;
    #2;
    checks++;
    if (bus.rd_data_o[2] !== 64'hFFFF_FFFF_1234_5678) begin
      failures++;
      $display("FAIL nanbox_port1_upper got=%h want=ffffffff12345678", bus.rd_data_o[2]);
    end
  endtask

  task automatic test_collision();
    idle();
    drive_wr(0, 7, 64'h11, 1'b0);
    drive_wr(1, 7, 64'h22, 1'b0);
    tick();
    idle();
    bus.rd_addr_i[0] = 5'd7;
    #2;
    checks++;
    if (bus.rd_data_o[0] !== 64'h22) begin
      failures++;
      $display("FAIL collision_high_port_wins got=%h want=22", bus.rd_data_o[0]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.rd_addr_i[0] = 5'd3;
    bus.issue_en_i   = 1'b1;
    bus.issue_addr_i = 5'd3;
    #2;
    checks++;
    if (bus.rd_busy_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL issue_same_cycle_busy got=%b want=0", bus.rd_busy_o[0]);
    end
    tick();
    idle();
    #2;
    checks++;
    if (bus.rd_busy_o[0] !== 1'b1 || bus.any_busy_o !== 1'b1) begin
      failures++;
      $display("FAIL issue_next_cycle_busy got=%b/%b want=1/1", bus.rd_busy_o[0], bus.any_busy_o);
    end
    drive_wr(0, 3, 64'h77, 1'b0);
    #2;
    checks++;
    if (bus.rd_busy_o[0] !== exp_busy(3)) begin
      failures++;
      $display("FAIL write_same_cycle_busy got=%b want=%b", bus.rd_busy_o[0], exp_busy(3));
    end
    tick();
    idle();
    #2;
    checks++;
    if (bus.rd_busy_o[0] !== 1'b0 || bus.any_busy_o !== 1'b0) begin
      failures++;
      $display("FAIL write_clears_busy got=%b/%b want=0/0", bus.rd_busy_o[0], bus.any_busy_o);
    end
    drive_wr(1, 3, 64'h88, 1'b0);
    bus.issue_en_i   = 1'b1;
    bus.issue_addr_i = 5'd3;
    tick();
    idle();
    #2;
    checks++;
    if (bus.rd_busy_o[0] !== 1'b1) begin
      failures++;
      $display("FAIL issue_beats_write got=%b want=1", bus.rd_busy_o[0]);
    end
    drive_wr(0, 3, 64'h99, 1'b0);
    tick();
    idle();
  endtask

  task automatic test_flush();
    int regs [3] = '{1, 2, 9};
    idle();
    foreach (regs[i]) begin
      bus.issue_en_i   = 1'b1;
      bus.issue_addr_i = AW'(regs[i]);
      tick();
    end
    idle();
    #2;
    checks++;
    if (bus.any_busy_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre_any_busy got=%b want=1", bus.any_busy_o);
    end
    bus.flush_i      = 1'b1;
    bus.issue_en_i   = 1'b1;
    bus.issue_addr_i = 5'd4;
    drive_wr(0, 10, 64'h55, 1'b0);
    tick();
    idle();
    bus.rd_addr_i[0] = 5'd4;
    bus.rd_addr_i[1] = 5'd9;
    bus.rd_addr_i[2] = 5'd10;
    #2;
    checks++;
    if (bus.any_busy_o !== 1'b0 || bus.rd_busy_o !== 3'b000) begin
      failures++;
      $display("FAIL flush_clears_all got=%b/%b want=0/000", bus.any_busy_o, bus.rd_busy_o);
    end
    checks++;
    if (bus.rd_data_o[2] !== 64'h55) begin
      failures++;
      $display("FAIL flush_keeps_write got=%h want=55", bus.rd_data_o[2]);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] want_now;
    idle();
    drive_wr(0, 8, 64'h1234, 1'b0);
    tick();
    idle();
    drive_wr(1, 8, 64'hABCD, 1'b0);
    bus.rd_addr_i[0] = 5'd8;
`ifdef FP_RF_BYPASS_EN
    want_now = 64'hABCD;
`else
    want_now = 64'h1234;
`endif
    #2;
    checks++;
    if (bus.rd_data_o[0] !== want_now || bus.rd_busy_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL bypass_same_cycle got=%h/%b want=%h/0", bus.rd_data_o[0], bus.rd_busy_o[0], want_now);
    end
    tick();
    idle();
    #2;
    checks++;
    if (bus.rd_data_o[0] !== 64'hABCD) begin
      failures++;
      $display("FAIL bypass_next_cycle got=%h want=abcd", bus.rd_data_o[0]);
    end
  endtask

  task automatic test_random();
    idle();
    for (int c = 0; c < 400; c++) begin
      for (int w = 0; w < NUM_WR; w++) begin
        bus.wr_en_i[w]     = ($urandom_range(0, 2) == 0);
        bus.wr_addr_i[w]   = AW'($urandom_range(0, 7));
        bus.wr_data_i[w]   = {$urandom, $urandom};
        bus.wr_single_i[w] = $urandom_range(0, 1) == 1;
      end
      bus.issue_en_i   = ($urandom_range(0, 2) == 0);
      bus.issue_addr_i = AW'($urandom_range(0, 7));
      bus.flush_i      = ($urandom_range(0, 15) == 0);
      for (int r = 0; r < NUM_RD; r++) bus.rd_addr_i[r] = AW'($urandom_range(0, 9));
      #2;
      for (int r = 0; r < NUM_RD; r++) begin
        checks++;
        if (bus.rd_data_o[r] !== exp_data(int'(bus.rd_addr_i[r])) ||
            bus.rd_busy_o[r] !== exp_busy(int'(bus.rd_addr_i[r]))) begin
          failures++;
          $display("FAIL random_read cyc=%0d port=%0d addr=%0d got=%h/%b want=%h/%b",
                   c, r, bus.rd_addr_i[r], bus.rd_data_o[r], bus.rd_busy_o[r],
                   exp_data(int'(bus.rd_addr_i[r])), exp_busy(int'(bus.rd_addr_i[r])));
        end
      end
      checks++;
      if (bus.any_busy_o !== exp_any()) begin
        failures++;
        $display("FAIL random_any_busy cyc=%0d got=%b want=%b", c, bus.any_busy_o, exp_any());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    drive_wr(0, 12, 64'hCAFE, 1'b0);
    bus.issue_en_i   = 1'b1;
    bus.issue_addr_i = 5'd13;
    tick();
    idle();
    bus.rd_addr_i[0] = 5'd12;
    bus.rd_addr_i[1] = 5'd13;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.rd_data_o[0] !== 64'h0 || bus.rd_busy_o[1] !== 1'b0 || bus.any_busy_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h/%b/%b want=0/0/0",
               bus.rd_data_o[0], bus.rd_busy_o[1], bus.any_busy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nanbox();
    test_collision();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
